// File: rtl/diff_accumulator.sv
// Accumulates signed 5-bit differences {borrow, d} from an upstream 4-bit subtractor over N_SAMPLES accepts.
// Define DIFF_ACCUMULATOR_SAT_EN to saturate acc at +127/-128 instead of wrapping.
module diff_accumulator #(
    parameter int N_SAMPLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] d,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] acc,
    output logic [3:0] borrow_cnt,
    output logic       mismatch,
    output logic       ovf,
    output logic       busy,
    output logic [1:0] dbg_state
);

    // Handshakes: a sample transfers on a rising edge where in_valid && in_ready;
    // results transfer where out_valid && out_ready. Valids never wait on readies.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] sample_cnt;
    logic       accept;
    logic       borrow;
    logic       last_sample;
    logic [3:0] d_expect;
    logic [7:0] diff;
    logic [8:0] sum;
    logic       sum_ovf;
    logic [7:0] acc_nxt;

    assign accept      = in_valid && in_ready;
    assign borrow      = (a < b);
    assign d_expect    = a - b;
    assign last_sample = (sample_cnt == 4'(N_SAMPLES - 1));
    assign diff        = {{4{borrow}}, d};
    // One guard bit: the sum left the signed 8-bit range when the top two bits disagree.
    assign sum         = {acc[7], acc} + {diff[7], diff};
    assign sum_ovf     = sum[8] ^ sum[7];

`ifdef DIFF_ACCUMULATOR_SAT_EN
    assign acc_nxt = sum_ovf ? (sum[8] ? 8'h80 : 8'h7F) : sum[7:0];
`else
    assign acc_nxt = sum[7:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && last_sample) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign dbg_state = state;

    // Results are only touched on start or accept, so they hold through DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= 8'h00;
            borrow_cnt <= 4'd0;
            sample_cnt <= 4'd0;
            mismatch   <= 1'b0;
            ovf        <= 1'b0;
        end else if (state == IDLE && start) begin
            acc        <= 8'h00;
            borrow_cnt <= 4'd0;
            sample_cnt <= 4'd0;
            mismatch   <= 1'b0;
            ovf        <= 1'b0;
        end else if (accept) begin
            acc        <= acc_nxt;
            sample_cnt <= sample_cnt + 4'd1;
            if (borrow) borrow_cnt <= borrow_cnt + 4'd1;
            if (d != d_expect) mismatch <= 1'b1;
            if (sum_ovf) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_diff_accumulator.sv
// Directed bench for diff_accumulator: an 8-sample instance and a 15-sample instance share the sample bus;
// expected results are queued per instance and checked by monitors on each result handshake.
module tb_diff_accumulator;

    logic       clk;
    logic       rst_n;
    logic       start1;
    logic       start2;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    logic       out_ready;

    logic       rdy1, ov1, mm1, of1, busy1;
    logic [7:0] acc1;
    logic [3:0] bc1;
    logic [1:0] st1;
    logic       rdy2, ov2, mm2, of2, busy2;
    logic [7:0] acc2;
    logic [3:0] bc2;
    logic [1:0] st2;

    logic [13:0] exp_q1[$];
    logic [13:0] exp_q2[$];
    int n_cmp;
    int n_err;

    diff_accumulator #(.N_SAMPLES(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid), .in_ready(rdy1),
        .a(a), .b(b), .d(d), .out_valid(ov1), .out_ready(out_ready),
        .acc(acc1), .borrow_cnt(bc1), .mismatch(mm1), .ovf(of1), .busy(busy1), .dbg_state(st1)
    );

    diff_accumulator #(.N_SAMPLES(15)) u_dut15 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .in_ready(rdy2),
        .a(a), .b(b), .d(d), .out_valid(ov2), .out_ready(out_ready),
        .acc(acc2), .borrow_cnt(bc2), .mismatch(mm2), .ovf(of2), .busy(busy2), .dbg_state(st2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // driver tasks
    task automatic wait_idle(input int sel);
        int n;
        n = 0;
        while ((sel == 1 ? busy1 : busy2) !== 1'b0) begin
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                timeout("wait_idle");
                break;
            end
        end
    endtask

    task automatic do_start(input int sel);
        wait_idle(sel);
        @(posedge clk); #1;
        if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic send(input int sel, input logic [3:0] av, input logic [3:0] bv, input logic [3:0] dv);
        logic taken;
        int n;
        a = av;
        b = bv;
        d = dv;
        in_valid = 1'b1;
        n = 0;
        forever begin
            taken = (sel == 1) ? rdy1 : rdy2;
            @(posedge clk); #1;
            if (taken) break;
            n++;
            if (n > 50) begin
                timeout("send");
                break;
            end
        end
    endtask

    task automatic gap();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // scoreboard monitors: pop on each result handshake
    always @(negedge clk) begin
        logic [13:0] e;
        if (ov1 === 1'b1 && out_ready === 1'b1) begin
            n_cmp++;
            if (exp_q1.size() == 0) begin
                n_err++;
                $display("FAIL result8: unexpected result %h", {acc1, bc1, mm1, of1});
            end else begin
                e = exp_q1.pop_front();
                if ({acc1, bc1, mm1, of1} !== e) begin
                    n_err++;
                    $display("FAIL result8: got acc=%h bc=%0d mm=%b ovf=%b expected acc=%h bc=%0d mm=%b ovf=%b",
                             acc1, bc1, mm1, of1, e[13:6], e[5:2], e[1], e[0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [13:0] e;
        if (ov2 === 1'b1 && out_ready === 1'b1) begin
            n_cmp++;
            if (exp_q2.size() == 0) begin
                n_err++;
                $display("FAIL result15: unexpected result %h", {acc2, bc2, mm2, of2});
            end else begin
                e = exp_q2.pop_front();
                if ({acc2, bc2, mm2, of2} !== e) begin
                    n_err++;
                    $display("FAIL result15: got acc=%h bc=%0d mm=%b ovf=%b expected acc=%h bc=%0d mm=%b ovf=%b",
                             acc2, bc2, mm2, of2, e[13:6], e[5:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        int n;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        in_valid = 1'b0;
        a = 4'd0;
        b = 4'd0;
        d = 4'd0;
        out_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc", {24'd0, acc1}, 32'h00);
        check("rst_flags", {25'd0, rdy1, ov1, busy1, mm1, of1, st1}, 32'h0);
        check("rst_bc", {28'd0, bc1}, 32'h0);
        rst_n = 1'b1;

        // zero differences
        exp_q1.push_back({8'h00, 4'd0, 1'b0, 1'b0});
        do_start(1);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("ov_before_last", {31'd0, ov1}, 32'd0);
            send(1, 4'd2, 4'd2, 4'd0);
        end
        in_valid = 1'b0;
        check("ov_latency_zero", {31'd0, ov1}, 32'd1);
        check("rdy_in_done", {31'd0, rdy1}, 32'd0);

        // all-borrow run, in_valid toggled every other cycle
        exp_q1.push_back({8'hE0, 4'd8, 1'b0, 1'b0});
        do_start(1);
        for (int i = 0; i < 8; i++) begin
            if (i != 0) gap();
            send(1, 4'd1, 4'd5, 4'd12);
        end
        in_valid = 1'b0;
        check("ov_latency_toggle", {31'd0, ov1}, 32'd1);

        // one corrupt difference, then a held DONE with start pulsed
        exp_q1.push_back({8'hE9, 4'd8, 1'b1, 1'b0});
        do_start(1);
        send(1, 4'd3, 4'd7, 4'd0);
        for (int i = 0; i < 7; i++) send(1, 4'd8, 4'd9, 4'd15);
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start1 = 1'b1;
            @(negedge clk);
            check("hold_acc", {24'd0, acc1}, 32'hE9);
            check("hold_bc_mm_ovf", {26'd0, bc1, mm1, of1}, {26'd0, 4'd8, 1'b1, 1'b0});
            check("hold_hs", {29'd0, ov1, rdy1, busy1}, 32'b101);
            @(posedge clk); #1;
        end
        start1 = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("done_to_idle", {28'd0, busy1, ov1, st1}, 32'h0);
        check("idle_keeps_acc", {24'd0, acc1}, 32'hE9);
        check("idle_keeps_mm", {31'd0, mm1}, 32'd1);

        // 15-sample instance: positive overflow
`ifdef DIFF_ACCUMULATOR_SAT_EN
        exp_q2.push_back({8'h7F, 4'd0, 1'b0, 1'b1});
`else
        exp_q2.push_back({8'hE1, 4'd0, 1'b0, 1'b1});
`endif
        do_start(2);
        for (int i = 0; i < 15; i++) send(2, 4'd15, 4'd0, 4'd15);
        in_valid = 1'b0;
        check("ov_latency_15", {31'd0, ov2}, 32'd1);
        check("idle8_during_15", {30'd0, busy1, rdy1}, 32'd0);

        // reset mid-run, then inputs ignored until start
        do_start(1);
        for (int i = 0; i < 3; i++) send(1, 4'd4, 4'd1, 4'd3);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_acc", {24'd0, acc1}, 32'h00);
        check("async_rst_flags", {25'd0, rdy1, ov1, busy1, mm1, of1, st1}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        a = 4'd7;
        b = 4'd1;
        d = 4'd6;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_ignore", {19'd0, acc1, bc1, rdy1}, 32'h0);
            check("post_rst_idle", {29'd0, busy1, st1}, 32'h0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // recovery run near the negative limit, no overflow
        exp_q1.push_back({8'h88, 4'd8, 1'b0, 1'b0});
        do_start(1);
        for (int i = 0; i < 8; i++) send(1, 4'd0, 4'd15, 4'd1);
        in_valid = 1'b0;

        // drain
        n = 0;
        while ((exp_q1.size() != 0 || exp_q2.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("q8_drained", exp_q1.size(), 32'd0);
        check("q15_drained", exp_q2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
